// File: rtl/a_axi_write_response_merger_2_to_1.sv
// a_axi_write_response_merger_2_to_1
//
// Merges the AXI4-Lite B channels of two SLRs into one host-facing B channel.
// Every broadcast write produces one response per SLR. Each SLR's responses
// are queued in its own 8-deep FIFO so the SLRs may skew. When both FIFOs
// hold an entry, the two heads are popped together and the worse code
// (numerically larger: DECERR > SLVERR > EXOKAY > OKAY) is loaded into a
// registered output.
//
// Optional feature macro: AXI_B_MISMATCH_DETECT_EN
//   When defined, adds the sticky output resp_mismatch. It sets on any merge
//   whose two heads differ and clears only on ap_rst.
//
// Ports
//   ap_clk                      in   clock, rising edge
//   ap_rst                      in   asynchronous active-high reset
//   s_axi_control_BVALID_slr_k  in   SLR k response valid
//   s_axi_control_BREADY_slr_k  out  SLR k response ready (FIFO k not full)
//   s_axi_control_BRESP_slr_k   in   SLR k response code
//   s_axi_control_BVALID        out  merged response valid to host
//   s_axi_control_BREADY        in   host ready
//   s_axi_control_BRESP         out  merged response code
//   resp_mismatch               out  sticky head mismatch flag (macro only)

module a_axi_write_response_merger_2_to_1 #(
  parameter int C_S_AXI_CONTROL_BRESP_WIDTH = 2,
  parameter int FIFO_ADDR_WIDTH             = 3
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst,
  input  logic                                   s_axi_control_BVALID_slr_0,
  output logic                                   s_axi_control_BREADY_slr_0,
  input  logic [C_S_AXI_CONTROL_BRESP_WIDTH-1:0] s_axi_control_BRESP_slr_0,
  input  logic                                   s_axi_control_BVALID_slr_1,
  output logic                                   s_axi_control_BREADY_slr_1,
  input  logic [C_S_AXI_CONTROL_BRESP_WIDTH-1:0] s_axi_control_BRESP_slr_1,
  output logic                                   s_axi_control_BVALID,
  input  logic                                   s_axi_control_BREADY,
  output logic [C_S_AXI_CONTROL_BRESP_WIDTH-1:0] s_axi_control_BRESP
`ifdef AXI_B_MISMATCH_DETECT_EN
  ,
  output logic                                   resp_mismatch
`endif
);

  localparam int W     = C_S_AXI_CONTROL_BRESP_WIDTH;
  localparam int A     = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << A;
  localparam logic [A:0] COUNT_FULL = (A+1)'(DEPTH);

  logic [W-1:0] mem_0 [DEPTH];
  logic [W-1:0] mem_1 [DEPTH];
  logic [A-1:0] wr_ptr_0, rd_ptr_0, wr_ptr_1, rd_ptr_1;
  logic [A:0]   count_0, count_1;

  logic         full_0, full_1, empty_0, empty_1;
  logic         push_0, push_1, merge;
  logic [W-1:0] head_0, head_1, worst;

  assign full_0  = (count_0 == COUNT_FULL);
  assign full_1  = (count_1 == COUNT_FULL);
  assign empty_0 = (count_0 == '0);
  assign empty_1 = (count_1 == '0);

  // Ready is gated by reset so neither SLR can hand off a response that the
  // reset is about to discard.
  assign s_axi_control_BREADY_slr_0 = ~ap_rst & ~full_0;
  assign s_axi_control_BREADY_slr_1 = ~ap_rst & ~full_1;

  assign push_0 = s_axi_control_BVALID_slr_0 & s_axi_control_BREADY_slr_0;
  assign push_1 = s_axi_control_BVALID_slr_1 & s_axi_control_BREADY_slr_1;

  // Both FIFOs always pop together, so responses pair strictly in order.
  // The output register may reload in the same cycle it is handed off.
  assign merge = ~empty_0 & ~empty_1 & (~s_axi_control_BVALID | s_axi_control_BREADY);

  // Heads come from registered state only. A new entry becomes visible the
  // cycle after its push, so there is no bypass path.
  assign head_0 = mem_0[rd_ptr_0];
  assign head_1 = mem_1[rd_ptr_1];
  assign worst  = (head_0 > head_1) ? head_0 : head_1;

  // Storage needs no reset; counts and pointers define what is valid.
  always_ff @(posedge ap_clk) begin
    if (push_0) mem_0[wr_ptr_0] <= s_axi_control_BRESP_slr_0;
    if (push_1) mem_1[wr_ptr_1] <= s_axi_control_BRESP_slr_1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_0 <= '0;
      rd_ptr_0 <= '0;
      count_0  <= '0;
    end else begin
      if (push_0) wr_ptr_0 <= wr_ptr_0 + 1'b1;
      if (merge)  rd_ptr_0 <= rd_ptr_0 + 1'b1;
      case ({push_0, merge})
        2'b10:   count_0 <= count_0 + 1'b1;
        2'b01:   count_0 <= count_0 - 1'b1;
        default: count_0 <= count_0;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_1 <= '0;
      rd_ptr_1 <= '0;
      count_1  <= '0;
    end else begin
      if (push_1) wr_ptr_1 <= wr_ptr_1 + 1'b1;
      if (merge)  rd_ptr_1 <= rd_ptr_1 + 1'b1;
      case ({push_1, merge})
        2'b10:   count_1 <= count_1 + 1'b1;
        2'b01:   count_1 <= count_1 - 1'b1;
        default: count_1 <= count_1;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s_axi_control_BVALID <= 1'b0;
      s_axi_control_BRESP  <= '0;
    end else if (merge) begin
      s_axi_control_BVALID <= 1'b1;
      s_axi_control_BRESP  <= worst;
    end else if (s_axi_control_BREADY) begin
      s_axi_control_BVALID <= 1'b0;
    end
  end

`ifdef AXI_B_MISMATCH_DETECT_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      resp_mismatch <= 1'b0;
    end else if (merge && (head_0 != head_1)) begin
      resp_mismatch <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_a_axi_write_response_merger_2_to_1.sv
// Self-checking bench for a_axi_write_response_merger_2_to_1.
// The reference model keeps per-SLR queues of accepted responses. It pairs
// them in arrival order and predicts the merged code as the larger of the two.
// Directed sequences cover latency, skew/full, host stall, and reset.
// Randomized traffic covers ordering and the merge rule.

module tb_a_axi_write_response_merger_2_to_1;

  logic       ap_clk = 1'b0;
  logic       ap_rst;
  logic       bvalid_0, bready_0, bvalid_1, bready_1;
  logic [1:0] bresp_0, bresp_1;
  logic       bvalid, bready;
  logic [1:0] bresp;
`ifdef AXI_B_MISMATCH_DETECT_EN
  logic       resp_mismatch;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_beats  = 0;
  int         beats_before;
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q_exp[$];
  logic       prev_hold = 1'b0;
  logic [1:0] prev_resp = 2'b00;
  logic [1:0] exp_seq [3];

  always #5 ap_clk = ~ap_clk;

  a_axi_write_response_merger_2_to_1 dut (
    .ap_clk                     (ap_clk),
    .ap_rst                     (ap_rst),
    .s_axi_control_BVALID_slr_0 (bvalid_0),
    .s_axi_control_BREADY_slr_0 (bready_0),
    .s_axi_control_BRESP_slr_0  (bresp_0),
    .s_axi_control_BVALID_slr_1 (bvalid_1),
    .s_axi_control_BREADY_slr_1 (bready_1),
    .s_axi_control_BRESP_slr_1  (bresp_1),
    .s_axi_control_BVALID       (bvalid),
    .s_axi_control_BREADY       (bready),
    .s_axi_control_BRESP        (bresp)
`ifdef AXI_B_MISMATCH_DETECT_EN
    ,
    .resp_mismatch              (resp_mismatch)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model and output monitor. Inputs change just after the rising
  // edge, so values seen at the falling edge are the ones the next rising
  // edge will act on.
  always @(negedge ap_clk) begin
    logic [1:0] a, b;
    if (ap_rst) begin
      q0.delete();
      q1.delete();
      q_exp.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_valid", bvalid, 1);
        check_eq("hold_resp", bresp, prev_resp);
      end
      if (bvalid && bready) begin
        check_eq("beat_expected", q_exp.size() != 0, 1);
        if (q_exp.size() != 0) check_eq("beat_resp", bresp, q_exp.pop_front());
        n_beats++;
      end
      if (bvalid_0 && bready_0) q0.push_back(bresp_0);
      if (bvalid_1 && bready_1) q1.push_back(bresp_1);
      while (q0.size() != 0 && q1.size() != 0) begin
        a = q0.pop_front();
        b = q1.pop_front();
        q_exp.push_back((a > b) ? a : b);
      end
      prev_hold = bvalid && !bready;
      prev_resp = bresp;
    end
  end

  task automatic drive(input logic v0, input logic [1:0] r0, input logic v1, input logic [1:0] r1);
    @(posedge ap_clk);
    #1;
    bvalid_0 = v0;
    bresp_0  = r0;
    bvalid_1 = v1;
    bresp_1  = r1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  task automatic do_reset();
    @(posedge ap_clk);
    #1;
    ap_rst   = 1'b1;
    bvalid_0 = 1'b0;
    bvalid_1 = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while ((q_exp.size() != 0 || bvalid) && i < budget) begin
      @(negedge ap_clk);
      i++;
    end
    check_eq("drain_queue", q_exp.size(), 0);
    check_eq("drain_bvalid", bvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ap_rst   = 1'b1;
    bvalid_0 = 1'b0;
    bvalid_1 = 1'b0;
    bresp_0  = 2'd0;
    bresp_1  = 2'd0;
    bready   = 1'b1;

    // Reset state
    @(negedge ap_clk);
    check_eq("rst_bready_0", bready_0, 0);
    check_eq("rst_bready_1", bready_1, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_bresp", bresp, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check_eq("post_rst_bready_0", bready_0, 1);
    check_eq("post_rst_bready_1", bready_1, 1);
`ifdef AXI_B_MISMATCH_DETECT_EN
    check_eq("rst_mismatch", resp_mismatch, 0);
`endif

    // Simultaneous OKAYs: valid exactly two cycles after the handshake, one beat.
    drive(1'b1, 2'd0, 1'b1, 2'd0);
    idle();
    @(negedge ap_clk);
    check_eq("lat_t1", bvalid, 0);
    idle();
    @(negedge ap_clk);
    check_eq("lat_t2_valid", bvalid, 1);
    check_eq("lat_t2_resp", bresp, 0);
`ifdef AXI_B_MISMATCH_DETECT_EN
    check_eq("okay_no_mismatch", resp_mismatch, 0);
`endif
    idle();
    @(negedge ap_clk);
    check_eq("one_beat", bvalid, 0);

    // Skewed OKAY / SLVERR: latency counts from the later SLR.
    drive(1'b1, 2'd0, 1'b0, 2'd0);
    repeat (3) idle();
    @(negedge ap_clk);
    check_eq("skew_wait", bvalid, 0);
    drive(1'b0, 2'd0, 1'b1, 2'd2);
    idle();
    @(negedge ap_clk);
    check_eq("slverr_t1", bvalid, 0);
`ifdef AXI_B_MISMATCH_DETECT_EN
    check_eq("mismatch_t1", resp_mismatch, 0);
`endif
    idle();
    @(negedge ap_clk);
    check_eq("slverr_valid", bvalid, 1);
    check_eq("slverr_resp", bresp, 2);
`ifdef AXI_B_MISMATCH_DETECT_EN
    check_eq("mismatch_set", resp_mismatch, 1);
`endif

    // DECERR paired with EXOKAY
    drive(1'b1, 2'd3, 1'b1, 2'd1);
    idle();
    idle();
    @(negedge ap_clk);
    check_eq("decerr_valid", bvalid, 1);
    check_eq("decerr_resp", bresp, 3);
    idle();
    wait_drain(20);
`ifdef AXI_B_MISMATCH_DETECT_EN
    check_eq("mismatch_sticky", resp_mismatch, 1);
`endif

    // SLR0 runs 8 ahead and fills; SLR1 catches up with 8.
    do_reset();
    drive(1'b1, 2'd0, 1'b0, 2'd0);
    repeat (7) begin
      @(posedge ap_clk);
      #1;
    end
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    check_eq("full_bready_0", bready_0, 0);
    check_eq("full_bready_1", bready_1, 1);
    check_eq("full_no_valid", bvalid, 0);
    repeat (3) begin
      @(posedge ap_clk);
      #1;
    end
    @(negedge ap_clk);
    check_eq("full_hold_bready_0", bready_0, 0);
    check_eq("full_hold_no_valid", bvalid, 0);
    beats_before = n_beats;
    @(posedge ap_clk);
    #1;
    bvalid_1 = 1'b1;
    bresp_1  = 2'd0;
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    check_eq("refill_t1_bready_0", bready_0, 0);
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    check_eq("refill_t2_valid", bvalid, 1);
    check_eq("refill_bready_0", bready_0, 1);
    @(posedge ap_clk);
    #1;
    bvalid_0 = 1'b0;
    repeat (5) begin
      @(posedge ap_clk);
      #1;
    end
    bvalid_1 = 1'b0;
    wait_drain(40);
    check_eq("skew_beats", n_beats - beats_before, 8);

    // Host stall with three pairs queued, then three back-to-back beats.
    do_reset();
    bready = 1'b0;
    drive(1'b1, 2'd0, 1'b1, 2'd1);
    drive(1'b1, 2'd2, 1'b1, 2'd0);
    drive(1'b1, 2'd3, 1'b1, 2'd3);
    idle();
    @(negedge ap_clk);
    repeat (10) begin
      @(negedge ap_clk);
      check_eq("stall_valid", bvalid, 1);
      check_eq("stall_resp", bresp, 1);
    end
    @(posedge ap_clk);
    #1;
    bready = 1'b1;
    exp_seq[0] = 2'd1;
    exp_seq[1] = 2'd2;
    exp_seq[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      check_eq("b2b_valid", bvalid, 1);
      check_eq("b2b_resp", bresp, exp_seq[i]);
    end
    @(negedge ap_clk);
    check_eq("b2b_end", bvalid, 0);

    // Reset with four pairs queued and the output valid.
    do_reset();
    bready = 1'b0;
    drive(1'b1, 2'd0, 1'b1, 2'd2);
    drive(1'b1, 2'd1, 1'b1, 2'd0);
    drive(1'b1, 2'd3, 1'b1, 2'd0);
    drive(1'b1, 2'd0, 1'b1, 2'd0);
    idle();
    repeat (3) @(negedge ap_clk);
    check_eq("pre_rst_valid", bvalid, 1);
`ifdef AXI_B_MISMATCH_DETECT_EN
    check_eq("pre_rst_mismatch", resp_mismatch, 1);
`endif
    beats_before = n_beats;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    check_eq("rst_async_valid", bvalid, 0);
    @(negedge ap_clk);
    check_eq("rst_mid_bready_0", bready_0, 0);
    check_eq("rst_mid_bready_1", bready_1, 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    bready = 1'b1;
    @(negedge ap_clk);
    check_eq("after_rst_bready_0", bready_0, 1);
    check_eq("after_rst_bready_1", bready_1, 1);
    check_eq("after_rst_valid", bvalid, 0);
`ifdef AXI_B_MISMATCH_DETECT_EN
    check_eq("after_rst_mismatch", resp_mismatch, 0);
`endif
    repeat (8) @(negedge ap_clk);
    check_eq("after_rst_no_beats", n_beats - beats_before, 0);

    // Randomized traffic with per-phase skew and random host back-pressure.
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      int p0, p1, ph_rdy;
      p0     = $urandom_range(10, 95);
      p1     = $urandom_range(10, 95);
      ph_rdy = $urandom_range(20, 100);
      for (int c = 0; c < 50; c++) begin
        @(posedge ap_clk);
        #1;
        bvalid_0 = ($urandom_range(0, 99) < p0);
        bresp_0  = 2'($urandom_range(0, 3));
        bvalid_1 = ($urandom_range(0, 99) < p1);
        bresp_1  = 2'($urandom_range(0, 3));
        bready   = ($urandom_range(0, 99) < ph_rdy);
      end
    end
    @(posedge ap_clk);
    #1;
    bvalid_0 = 1'b0;
    bvalid_1 = 1'b0;
    bready   = 1'b1;
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
